// File: rtl/adc_sample_avg.sv
//-----------------------------------------------------------------------------
// adc_sample_avg
//   Averages windows of 2^AVG_LOG2 ADC samples and reports the rounded mean,
//   minimum and maximum of each completed window.
//
//   A sample is taken on the rising edge of the sample_en level, so a
//   data-valid strobe held high for many clocks counts as one sample.
//   The averaging FSM has three states:
//     IDLE  : nothing accumulated yet
//     ACCUM : window partly filled
//     DONE  : window just completed; the results are presented for this
//             single cycle, with avg_valid high
//   The result registers load on the edge that accepts the final sample,
//   so avg_out/min_out/max_out are already valid in the DONE cycle.
//
// Parameters
//   AVG_LOG2   log2 of samples per window, legal range 0..4
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sample_in  ADC conversion result, valid while sample_en is high
//   sample_en  ADC data-valid level
//   clr        synchronous window clear (overrides sample_en)
//   avg_out    rounded mean of the last completed window
//   avg_valid  one-cycle pulse when avg_out/min_out/max_out update
//   min_out    minimum sample of the last completed window
//   max_out    maximum sample of the last completed window
//   win_cnt    samples accepted in the current window
//   thr_hi     alarm threshold      (only with ADC_AVG_ALARM_EN)
//   alarm      average > thr_hi     (only with ADC_AVG_ALARM_EN)
//
// Build option
//   ADC_AVG_ALARM_EN  adds the thr_hi input and alarm output.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module adc_sample_avg #(
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        sample_in,
    input  logic              sample_en,
    input  logic              clr,
`ifdef ADC_AVG_ALARM_EN
    input  logic [7:0]        thr_hi,
    output logic              alarm,
`endif
    output logic [7:0]        avg_out,
    output logic              avg_valid,
    output logic [7:0]        min_out,
    output logic [7:0]        max_out,
    output logic [AVG_LOG2:0] win_cnt
);

    localparam int ACC_W = 8 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int FULL  = 1 << AVG_LOG2;
    // Half an LSB of the result, so the shift rounds half up.
    localparam int RND_I = (AVG_LOG2 == 0) ? 0 : (1 << (AVG_LOG2 - 1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         mn_q, mn_d;
    logic [7:0]         mx_q, mx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_q;
    logic               accept;
    logic               load;
    logic [ACC_W-1:0]   sum_rnd;
    logic [7:0]         avg_d;
    logic               avg_valid_q;

    // The edge detector keeps tracking sample_en even while clr is high.
    assign accept = sample_en & ~en_q & ~clr;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mn_d    = mn_q;
        mx_d    = mx_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                // A sample taken in DONE starts the next window directly.
                if (accept) begin
                    acc_d   = ACC_W'(sample_in);
                    mn_d    = sample_in;
                    mx_d    = sample_in;
                    cnt_d   = CNT_W'(1);
                    state_d = (AVG_LOG2 == 0) ? DONE : ACCUM;
                end else begin
                    acc_d   = '0;
                    mn_d    = 8'hFF;
                    mx_d    = 8'h00;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_q + ACC_W'(sample_in);
                    mn_d  = (sample_in < mn_q) ? sample_in : mn_q;
                    mx_d  = (sample_in > mx_q) ? sample_in : mx_q;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(FULL))
                        state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            acc_d   = '0;
            mn_d    = 8'hFF;
            mx_d    = 8'h00;
            cnt_d   = '0;
            state_d = IDLE;
        end

        // Entering DONE means acc_d/mn_d/mx_d hold the complete window.
        load    = (state_d == DONE);
        // 255*2^N + 2^(N-1) < 2^(8+N): the rounding add cannot overflow.
        sum_rnd = acc_d + ACC_W'(RND_I);
        avg_d   = 8'(sum_rnd >> AVG_LOG2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mn_q        <= 8'hFF;
            mx_q        <= 8'h00;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            avg_out     <= 8'h00;
            min_out     <= 8'h00;
            max_out     <= 8'h00;
            avg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mn_q        <= mn_d;
            mx_q        <= mx_d;
            cnt_q       <= cnt_d;
            en_q        <= sample_en;
            avg_valid_q <= load;
            if (load) begin
                avg_out <= avg_d;
                min_out <= mn_d;
                max_out <= mx_d;
            end
        end
    end

    // A clr in the DONE cycle hides the pulse.
    assign avg_valid = avg_valid_q & ~clr;
    assign win_cnt   = cnt_q;

`ifdef ADC_AVG_ALARM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alarm <= 1'b0;
        else if (clr)
            alarm <= 1'b0;
        else if (load)
            alarm <= (avg_d > thr_hi);
    end
`endif

endmodule

// File: tb/tb_adc_sample_avg.sv
`timescale 1ns/1ps

module tb_adc_sample_avg;

    typedef struct packed {
        logic [7:0][7:0] s;
        logic [7:0]      avg;
        logic [7:0]      mn;
        logic [7:0]      mx;
    } vec_t;

    typedef struct packed {
        logic [7:0]  avg;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [31:0] cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sample_in;
    logic       sample_en;
    logic       clr;
    logic [7:0] avg_out, min_out, max_out;
    logic       avg_valid;
    logic [3:0] win_cnt;

    logic [7:0] in0;
    logic       en0;
    logic       clr0;
    logic [7:0] avg0, min0, max0;
    logic       vld0;
    logic [0:0] cnt0;

`ifdef ADC_AVG_ALARM_EN
    logic [7:0] thr_hi;
    logic       alarm;
    logic       alarm0;
`endif

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] cyc = 0;
    exp_t        sb[$];
    vec_t        vt[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_sample_avg #(.AVG_LOG2(3)) u_avg (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_in (sample_in),
        .sample_en (sample_en),
        .clr       (clr),
`ifdef ADC_AVG_ALARM_EN
        .thr_hi    (thr_hi),
        .alarm     (alarm),
`endif
        .avg_out   (avg_out),
        .avg_valid (avg_valid),
        .min_out   (min_out),
        .max_out   (max_out),
        .win_cnt   (win_cnt)
    );

    adc_sample_avg #(.AVG_LOG2(0)) u_avg0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_in (in0),
        .sample_en (en0),
        .clr       (clr0),
`ifdef ADC_AVG_ALARM_EN
        .thr_hi    (thr_hi),
        .alarm     (alarm0),
`endif
        .avg_out   (avg0),
        .avg_valid (vld0),
        .min_out   (min0),
        .max_out   (max0),
        .win_cnt   (cnt0)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every avg_valid pulse must match the oldest expected window,
    // including the cycle in which it appears.
    always @(negedge clk) begin
        if (rst_n && avg_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("avg_out", avg_out, e.avg);
                check("min_out", min_out, e.mn);
                check("max_out", max_out, e.mx);
                check("valid_latency", cyc, e.cyc);
            end
        end
    end

    // One sample: rising edge on sample_en, held hi cycles, then one low cycle.
    task automatic pulse(input logic [7:0] s, input int hi, input bit last, input exp_t e);
        sample_in = s;
        sample_en = 1'b1;
        @(posedge clk); #1;
        if (last) begin
            e.cyc = cyc;       // pulse due in the cycle right after acceptance
            sb.push_back(e);
        end
        if (hi > 1) begin
            repeat (hi - 1) @(posedge clk);
            #1;
        end
        sample_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic window(input vec_t v, input int hi);
        exp_t e;
        e.avg = v.avg; e.mn = v.mn; e.mx = v.mx; e.cyc = 0;
        for (int k = 0; k < 8; k++) begin
            pulse(v.s[k], hi, k == 7, e);
            if (k == 3) check("win_cnt_mid", {28'd0, win_cnt}, 32'd4);
        end
        check("win_cnt_end", {28'd0, win_cnt}, 32'd0);
        check("avg_hold", avg_out, v.avg);
    endtask

    task automatic flat_window(input logic [7:0] s, input int hi);
        vec_t v;
        v.s = {8{s}}; v.avg = s; v.mn = s; v.mx = s;
        window(v, hi);
    endtask

    initial begin
        exp_t e0;
        vec_t v;
        logic [7:0] held;

        e0 = '0;
        vt[0] = '{s: {8'd81, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10},
                  avg: 8'd45, mn: 8'd10, mx: 8'd81};
        vt[1] = '{s: {8{8'd255}}, avg: 8'd255, mn: 8'd255, mx: 8'd255};
        vt[2] = '{s: {8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                  avg: 8'd1, mn: 8'd0, mx: 8'd4};      // 4+4>>3: rounds up
        vt[3] = '{s: {8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                  avg: 8'd0, mn: 8'd0, mx: 8'd3};      // 3+4>>3: rounds down
        vt[4] = '{s: {8'd64, 8'd128, 8'd254, 8'd1, 8'd99, 8'd13, 8'd200, 8'd7},
                  avg: 8'd96, mn: 8'd1, mx: 8'd254};   // 766+4>>3

        rst_n = 1'b0; sample_in = 0; sample_en = 0; clr = 0;
        in0 = 0; en0 = 0; clr0 = 0;
`ifdef ADC_AVG_ALARM_EN
        thr_hi = 8'd128;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_avg", avg_out, 0);
        check("rst_min", min_out, 0);
        check("rst_max", max_out, 0);
        check("rst_valid", avg_valid, 0);
        check("rst_cnt", {28'd0, win_cnt}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven windows with varying sample_en high time.
        for (int i = 0; i < 5; i++) window(vt[i], 1 + (i % 3));

        // Long strobes count once each.
        flat_window(8'd100, 20);

        // Partial window then clr: nothing reported, outputs untouched.
        held = avg_out;
        for (int k = 0; k < 5; k++) pulse(8'd50, 1, 1'b0, e0);
        check("cnt_before_clr", {28'd0, win_cnt}, 5);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("cnt_after_clr", {28'd0, win_cnt}, 0);
        check("avg_after_clr", avg_out, held);
        @(posedge clk); #1;
        flat_window(8'd200, 1);

        // clr during the DONE cycle hides the pulse.
        for (int k = 0; k < 7; k++) pulse(8'd9, 1, 1'b0, e0);
        sample_in = 8'd9; sample_en = 1'b1;
        @(posedge clk); #1;
        clr = 1'b1; sample_en = 1'b0;
        @(negedge clk);
        check("valid_masked_by_clr", avg_valid, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        check("cnt_after_done_clr", {28'd0, win_cnt}, 0);

        // Reset mid-window: immediate clear, partial window discarded.
        for (int k = 0; k < 3; k++) pulse(8'd77, 1, 1'b0, e0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_avg", avg_out, 0);
        check("midrst_min", min_out, 0);
        check("midrst_max", max_out, 0);
        check("midrst_cnt", {28'd0, win_cnt}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        v = '{s: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
              avg: 8'd5, mn: 8'd1, mx: 8'd8};          // 36+4>>3
        window(v, 2);

`ifdef ADC_AVG_ALARM_EN
        flat_window(8'd129, 1);
        check("alarm_set", alarm, 1);
        flat_window(8'd128, 1);
        check("alarm_clear", alarm, 0);
`endif

        // AVG_LOG2=0: every sample is its own window.
        for (int i = 0; i < 3; i++) begin
            logic [7:0] s;
            s = (i == 0) ? 8'd17 : (i == 1) ? 8'd255 : 8'd0;
            in0 = s; en0 = 1'b1;
            @(negedge clk);
            check("n0_no_early_valid", vld0, 0);
            @(posedge clk); #1;
            en0 = 1'b0;
            @(negedge clk);
            check("n0_valid", vld0, 1);
            check("n0_avg", avg0, s);
            check("n0_min", min0, s);
            @(posedge clk); #1;
            check("n0_valid_one_cycle", vld0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
